// File: rtl/bus_dec_sel.sv
// Bus address decoder with a one-hot slave select, per-slave presence mask,
// ack handshake, timeout and a one-cycle turnaround gap between transfers.
module bus_dec_sel #(
    parameter int SEL_W      = 4,
    parameter int TIMEOUT    = 15,
    parameter int ACTIVE_LOW = 0,
    localparam int N         = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req,
    input  logic [SEL_W-1:0] addr,
    input  logic [N-1:0]     mask,
    input  logic [N-1:0]     ack,
    output logic [N-1:0]     sel,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [N-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     sel_reg, sel_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] addr_q_reg, addr_q_next;
    logic [N-1:0]     addr_dec;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign addr_dec[gi] = (addr == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        cnt_next    = cnt_reg;
        addr_q_next = addr_q_reg;
        case (state_reg)
            IDLE: begin
                if (req && en) begin
                    if (mask[addr]) begin
                        state_next  = ACTIVE;
                        addr_q_next = addr;
                        sel_next    = SEL_OFF ^ addr_dec;
                        busy_next   = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // Disable aborts silently; otherwise ack beats the timeout in the same cycle.
                if (!en) begin
                    state_next = GAP;
                    sel_next   = SEL_OFF;
                end else if (ack[addr_q_reg]) begin
                    state_next = GAP;
                    sel_next   = SEL_OFF;
                    done_next  = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = GAP;
                    sel_next   = SEL_OFF;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                sel_next   = SEL_OFF;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            sel_reg    <= SEL_OFF;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
            addr_q_reg <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
            addr_q_reg <= addr_q_next;
        end
    end

    assign sel  = sel_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule
